// File: rtl/clk_div_bank.sv
// Bank of independent 50%-duty clock dividers with a tick on each rising edge.
// Half-period updates are shadowed while running and applied only at a toggle boundary.
module clk_div_bank #(
    parameter int unsigned  NUM_CH     = 3,
    parameter int unsigned  DIV_W      = 8,
    parameter int unsigned  RESET_HALF = 8,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    // Out-of-range channels keep cfg_ready high so their writes drain and vanish.
    always_comb begin
        cfg_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_ch == CH_W'(c)) begin
                cfg_ready = ~pending[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_active;
        logic [DIV_W-1:0] r_shadow;
        logic             r_clk;
        logic             r_tick;
        logic             r_pend;
        logic             w_idle;
        logic             w_wrap;
        logic             w_acc;

        assign w_idle = ~en[c] | (r_active == '0);
        assign w_wrap = (r_cnt == r_active - DIV_W'(1));
        assign w_acc  = cfg_valid & ~r_pend & (cfg_ch == CH_W'(c));

        always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_active <= DIV_W'(RESET_HALF);
                r_shadow <= '0;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
                r_pend   <= 1'b0;
            end else if (w_idle) begin
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
                if (r_pend) begin
                    r_active <= r_shadow;
                    r_pend   <= 1'b0;
                end else if (w_acc) begin
                    r_active <= cfg_half;
                end
            end else begin
                if (w_wrap) begin
                    r_cnt <= '0;
                    // A zero half-period parks the output low instead of toggling.
                    if (r_pend && (r_shadow == '0)) begin
                        r_clk  <= 1'b0;
                        r_tick <= 1'b0;
                    end else begin
                        r_clk  <= ~r_clk;
                        r_tick <= ~r_clk;
                    end
                    if (r_pend) begin
                        r_active <= r_shadow;
                        r_pend   <= 1'b0;
                    end
                end else begin
                    r_cnt  <= r_cnt + DIV_W'(1);
                    r_tick <= 1'b0;
                end
                if (w_acc) begin
                    r_shadow <= cfg_half;
                    r_pend   <= 1'b1;
                end
            end
        end

        assign clk_out[c] = r_clk;
        assign tick[c]    = r_tick;
        assign pending[c] = r_pend;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank (NUM_CH=3, DIV_W=8, RESET_HALF=8).
module tb_clk_div_bank;

    logic       clk_50M = 1'b0;
    logic       rst_n   = 1'b1;
    logic [2:0] en;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_half;
    logic       cfg_ready;
    logic [2:0] clk_out;
    logic [2:0] tick;
    logic [2:0] pending;

    int n_assert = 0;
    int n_fail   = 0;

    clk_div_bank #(
        .NUM_CH     (3),
        .DIV_W      (8),
        .RESET_HALF (8)
    ) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            @(negedge clk_50M);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        en        = 3'b000;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_half  = 8'd0;
        #3 rst_n  = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        int tk;

        // 1: default divide-by-16 on ch0
        do_reset();
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
        en = 3'b001;
        step(7);
        chk("t1_before_rise", 32'(clk_out), 32'h0);
        step(1);
        chk("t1_first_rise", 32'(clk_out), 32'h1);
        chk("t1_first_tick", 32'(tick), 32'h1);
        step(1);
        chk("t1_tick_one_cycle", 32'(tick), 32'h0);
        step(6);
        chk("t1_high_e15", 32'(clk_out), 32'h1);
        step(1);
        chk("t1_fall_e16", 32'(clk_out), 32'h0);
        step(8);
        chk("t1_second_rise", 32'(tick), 32'h1);
        hi = 0;
        tk = 0;
        for (int i = 0; i < 16; i++) begin
            hi += int'(clk_out[0]);
            tk += int'(tick[0]);
            step(1);
        end
        chk("t1_high_count", 32'(hi), 32'd8);
        chk("t1_tick_count", 32'(tk), 32'd1);

        // 2: shadowed write on running ch0 (E=40, just rose)
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_half  = 8'd25;
        #1 chk("t2_ready_before", 32'(cfg_ready), 32'h1);
        step(1);
        cfg_valid = 1'b0;
        chk("t2_pending_set", 32'(pending), 32'h1);
        #1 chk("t2_ready_stall", 32'(cfg_ready), 32'h0);
        step(6);
        chk("t2_old_half_high", 32'(clk_out), 32'h1);
        chk("t2_still_pending", 32'(pending), 32'h1);
        step(1);
        chk("t2_fall_old_half", 32'(clk_out), 32'h0);
        chk("t2_pending_clear", 32'(pending), 32'h0);
        step(24);
        chk("t2_low_e72", 32'(clk_out), 32'h0);
        step(1);
        chk("t2_rise_e73", 32'(tick), 32'h1);
        step(24);
        chk("t2_high_e97", 32'(clk_out), 32'h1);
        step(1);
        chk("t2_fall_e98", 32'(clk_out), 32'h0);
        step(25);
        chk("t2_rise_e123", 32'(tick), 32'h1);

        // 3: back-to-back writes to ch1, ch2 write slips in during the stall
        do_reset();
        en = 3'b010;
        step(2);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_half  = 8'd4;
        #1 chk("t3_ready_first", 32'(cfg_ready), 32'h1);
        step(1);
        chk("t3_pending_ch1", 32'(pending), 32'h2);
        cfg_half = 8'd6;
        #1 chk("t3_ready_stall", 32'(cfg_ready), 32'h0);
        cfg_ch   = 2'd2;
        cfg_half = 8'd5;
        #1 chk("t3_ready_ch2", 32'(cfg_ready), 32'h1);
        step(1);
        chk("t3_ch2_no_pending", 32'(pending), 32'h2);
        cfg_ch   = 2'd1;
        cfg_half = 8'd6;
        step(3);
        chk("t3_pending_e7", 32'(pending), 32'h2);
        chk("t3_low_e7", 32'(clk_out), 32'h0);
        step(1);
        chk("t3_rise_e8", 32'(clk_out), 32'h2);
        chk("t3_tick_e8", 32'(tick), 32'h2);
        chk("t3_ready_e8", 32'(cfg_ready), 32'h1);
        step(1);
        cfg_valid = 1'b0;
        chk("t3_second_accepted", 32'(pending), 32'h2);
        step(2);
        chk("t3_high_e11", 32'(clk_out), 32'h2);
        step(1);
        chk("t3_fall_h4", 32'(clk_out), 32'h0);
        chk("t3_pending_clr", 32'(pending), 32'h0);
        step(5);
        chk("t3_low_e17", 32'(clk_out), 32'h0);
        step(1);
        chk("t3_rise_h6", 32'(tick), 32'h2);
        en = 3'b110;
        step(4);
        chk("t3_ch2_low", 32'(clk_out), 32'h2);
        step(1);
        chk("t3_ch2_rise_h5", 32'(clk_out), 32'h6);
        chk("t3_ch2_tick", 32'(tick), 32'h4);

        // 4: stop ch2 with half=0, restart with half=2, out-of-range write
        do_reset();
        en = 3'b100;
        step(8);
        chk("t4_rise_e8", 32'(clk_out), 32'h4);
        step(2);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_half  = 8'd0;
        step(1);
        cfg_valid = 1'b0;
        chk("t4_pending_zero", 32'(pending), 32'h4);
        #1 chk("t4_ready_stall", 32'(cfg_ready), 32'h0);
        step(4);
        chk("t4_high_e15", 32'(clk_out), 32'h4);
        step(1);
        chk("t4_stop_low", 32'(clk_out), 32'h0);
        chk("t4_stop_pend_clr", 32'(pending), 32'h0);
        step(4);
        chk("t4_stays_low", 32'(clk_out), 32'h0);
        cfg_valid = 1'b1;
        cfg_half  = 8'd2;
        #1 chk("t4_ready_idle", 32'(cfg_ready), 32'h1);
        step(1);
        cfg_valid = 1'b0;
        chk("t4_direct_apply", 32'(pending), 32'h0);
        step(1);
        chk("t4_low_e22", 32'(clk_out), 32'h0);
        step(1);
        chk("t4_restart_rise", 32'(clk_out), 32'h4);
        chk("t4_restart_tick", 32'(tick), 32'h4);
        step(2);
        chk("t4_fall_e25", 32'(clk_out), 32'h0);
        step(2);
        chk("t4_rise_e27", 32'(tick), 32'h4);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_half  = 8'd1;
        #1 chk("t4_ready_oob", 32'(cfg_ready), 32'h1);
        step(1);
        cfg_valid = 1'b0;
        chk("t4_oob_no_pending", 32'(pending), 32'h0);
        step(3);
        chk("t4_oob_no_effect", 32'(clk_out), 32'h4);
        chk("t4_oob_tick", 32'(tick), 32'h4);

        // 5: en drop while high, re-enable, async reset mid-run
        do_reset();
        en = 3'b001;
        step(8);
        chk("t5_rise_e8", 32'(clk_out), 32'h1);
        step(2);
        en = 3'b000;
        step(1);
        chk("t5_forced_low", 32'(clk_out), 32'h0);
        chk("t5_no_tick", 32'(tick), 32'h0);
        en = 3'b001;
        step(7);
        chk("t5_reen_low", 32'(clk_out), 32'h0);
        step(1);
        chk("t5_reen_rise", 32'(clk_out), 32'h1);
        chk("t5_reen_tick", 32'(tick), 32'h1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_half  = 8'd3;
        step(1);
        cfg_valid = 1'b0;
        chk("t5_pending_pre_rst", 32'(pending), 32'h1);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_clk", 32'(clk_out), 32'h0);
        chk("t5_async_pend", 32'(pending), 32'h0);
        chk("t5_async_tick", 32'(tick), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(7);
        chk("t5_post_rst_low", 32'(clk_out), 32'h0);
        step(1);
        chk("t5_post_rst_h8", 32'(clk_out), 32'h1);
        chk("t5_post_rst_tick", 32'(tick), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
